conv_layer_seq: RTL

// - Time-multiplexed K-filter 2-D convolution engine: one MAC per cycle over all D*F*F taps per output pixel.
// - Adds stride, optional ReLU, signed fixed-point saturation and a start/done plus valid/ready output stream.
// - Sits between the image buffer and the pooling/activation stage of the CNN pipeline.
// - Replaces the fully parallel per-filter conv instances where area matters more than throughput.

---
 rtl/conv_layer_seq_pkg.sv | 37 +++
 rtl/conv_layer_seq_mac.sv | 60 ++++++
 rtl/conv_layer_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_seq_pkg.sv
// Shared types and sizing helpers for the sequential convolution engine.
package conv_layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Counter/index width with a floor of one bit.
    function automatic int unsigned cw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Output extent of one spatial dimension for a given filter size and stride.
    function automatic int unsigned out_dim(input int unsigned n, input int unsigned f,
                                            input int unsigned s);
        return (n - f) / s + 1;
    endfunction

    // Accumulator width that cannot overflow across all taps.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned taps);
        return 2 * dw + $clog2(taps);
    endfunction

    // Signed saturation bounds for a dw-bit word.
    function automatic longint sat_max(input int unsigned dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/conv_layer_seq_mac.sv
// Signed multiply-accumulate with clear/enable and a shift/saturate/ReLU output stage.
module conv_layer_seq_mac
    import conv_layer_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned ACC_W      = 36,
    parameter int unsigned RELU       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_result_c
);

    localparam logic signed [ACC_W-1:0]      SAT_HI = ACC_W'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0]      SAT_LO = ACC_W'(sat_min(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] OUT_HI = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] OUT_LO = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_W-1:0]        r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]        w_sum;
    logic signed [ACC_W-1:0]        w_shift;

    // Running sum including the current tap, so the final result is available on the last tap.
    always_comb begin
        w_prod  = i_a * i_b;
        w_sum   = r_acc + ACC_W'(w_prod);
        w_shift = w_sum >>> FRAC;
    end

    // Saturate to the output word, then optionally clamp negatives.
    always_comb begin
        o_result_c = DATA_WIDTH'(w_shift);
        if (w_shift > SAT_HI) begin
            o_result_c = OUT_HI;
        end else if (w_shift < SAT_LO) begin
            o_result_c = OUT_LO;
        end
        if ((RELU != 0) && o_result_c[DATA_WIDTH-1]) begin
            o_result_c = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// Time-multiplexed K-filter 2-D convolution: one MAC per cycle, valid/ready output stream.
module conv_layer_seq
    import conv_layer_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned D          = 1,
    parameter int unsigned H          = 8,
    parameter int unsigned W          = 8,
    parameter int unsigned F          = 3,
    parameter int unsigned K          = 2,
    parameter int unsigned S          = 1,
    parameter int unsigned RELU       = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [D*H*W*DATA_WIDTH-1:0]         image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]       filters,
    output logic                                busy,
    output logic                                done,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [cw(K)-1:0]                    out_k,
    output logic [cw(out_dim(H, F, S))-1:0]     out_row,
    output logic [cw(out_dim(W, F, S))-1:0]     out_col
);

    localparam int unsigned HO    = out_dim(H, F, S);
    localparam int unsigned WO    = out_dim(W, F, S);
    localparam int unsigned TAPS  = D * F * F;
    localparam int unsigned ACC_W = acc_w(DATA_WIDTH, TAPS);
    localparam int unsigned KW    = cw(K);
    localparam int unsigned RW    = cw(HO);
    localparam int unsigned CW    = cw(WO);
    localparam int unsigned DDW   = cw(D);
    localparam int unsigned FW    = cw(F);
    localparam int unsigned IMG_IW = cw(D * H * W * DATA_WIDTH);
    localparam int unsigned FLT_IW = cw(K * D * F * F * DATA_WIDTH);

    state_t                         r_state;
    state_t                         w_next;
    logic [KW-1:0]                  r_k;
    logic [RW-1:0]                  r_row;
    logic [CW-1:0]                  r_col;
    logic [DDW-1:0]                 r_d;
    logic [FW-1:0]                  r_i;
    logic [FW-1:0]                  r_j;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_valid;
    logic [DATA_WIDTH-1:0]          r_data;
    logic [KW-1:0]                  r_out_k;
    logic [RW-1:0]                  r_out_row;
    logic [CW-1:0]                  r_out_col;
    logic                           w_last_tap;
    logic                           w_last_pix;
    logic [IMG_IW-1:0]              w_img_lsb;
    logic [FLT_IW-1:0]              w_flt_lsb;
    logic signed [DATA_WIDTH-1:0]   w_pix;
    logic signed [DATA_WIDTH-1:0]   w_flt;
    logic signed [DATA_WIDTH-1:0]   w_result;

    // Tap/pixel boundary detection and operand selection for the current tap.
    always_comb begin
        w_last_tap = (r_d == DDW'(D - 1)) && (r_i == FW'(F - 1)) && (r_j == FW'(F - 1));
        w_last_pix = (r_k == KW'(K - 1)) && (r_row == RW'(HO - 1)) && (r_col == CW'(WO - 1));
        w_img_lsb  = IMG_IW'(((32'(r_d) * H + 32'(r_row) * S + 32'(r_i)) * W
                              + 32'(r_col) * S + 32'(r_j)) * DATA_WIDTH);
        w_flt_lsb  = FLT_IW'((((32'(r_k) * D + 32'(r_d)) * F + 32'(r_i)) * F
                              + 32'(r_j)) * DATA_WIDTH);
        w_pix      = image[w_img_lsb +: DATA_WIDTH];
        w_flt      = filters[w_flt_lsb +: DATA_WIDTH];
    end

    conv_layer_seq_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC       (FRAC),
        .ACC_W      (ACC_W),
        .RELU       (RELU)
    ) u_mac (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (r_state == ST_LOAD),
        .i_en       (r_state == ST_MAC),
        .i_a        (w_pix),
        .i_b        (w_flt),
        .o_result_c (w_result)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_MAC;
            ST_MAC:  if (w_last_tap) w_next = ST_OUT;
            ST_OUT:  if (out_ready) w_next = w_last_pix ? ST_DONE : ST_LOAD;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters, output registers and status flags; OUT without ready freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_d       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_out_k   <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
        end else begin
            r_busy  <= (w_next != ST_IDLE) && (w_next != ST_DONE);
            r_done  <= (w_next == ST_DONE);
            r_valid <= (w_next == ST_OUT);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_k   <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                ST_LOAD: begin
                    r_d <= '0;
                    r_i <= '0;
                    r_j <= '0;
                end
                ST_MAC: begin
                    if (r_j == FW'(F - 1)) begin
                        r_j <= '0;
                        if (r_i == FW'(F - 1)) begin
                            r_i <= '0;
                            r_d <= r_d + 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                    if (w_last_tap) begin
                        r_data    <= w_result;
                        r_out_k   <= r_k;
                        r_out_row <= r_row;
                        r_out_col <= r_col;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (w_last_pix) begin
                            r_k   <= '0;
                            r_row <= '0;
                            r_col <= '0;
                        end else if (r_col == CW'(WO - 1)) begin
                            r_col <= '0;
                            if (r_row == RW'(HO - 1)) begin
                                r_row <= '0;
                                r_k   <= r_k + 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_k     = r_out_k;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;

endmodule
